// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  // Detector FSM states; encoding is visible on the debug LEDs.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2,
    S_HIT   = 2'd3
  } det_state_t;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  // Width needed to hold a fill level of 0..pat_len.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_2,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = (r_q == {W{1'b1}});
  assign q        = r_q;

  // Count register with synchronous clear and saturation.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_q <= '0;
    end else if (inc && !w_at_max) begin
      r_q <= r_q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the last PAT_LEN accepted bits against a
// loadable pattern, pulses match for one cycle and keeps a saturating count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                               clk_2,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic                               in_bit,
  input  logic                               pat_load,
  input  logic [PAT_LEN-1:0]                 pat_in,
  input  logic                               overlap,
  output logic                               match,
  output logic [CNT_W-1:0]                   match_count,
  output logic [fill_width(PAT_LEN)-1:0]     fill,
  output logic [1:0]                         state_o
);

  localparam int unsigned FW = fill_width(PAT_LEN);

  logic [PAT_LEN-1:0] r_history;
  logic [PAT_LEN-1:0] r_pattern;
  logic [FW-1:0]      r_fill;
  det_state_t         r_state;
  logic               r_match;

  logic [PAT_LEN-1:0] w_history_nxt;
  logic [PAT_LEN-1:0] w_pattern_nxt;
  logic [FW-1:0]      w_fill_nxt;
  det_state_t         w_state_nxt;
  logic               w_match_nxt;

  logic [PAT_LEN-1:0] w_nh;
  logic [FW-1:0]      w_nf;
  logic               w_accept;
  logic               w_hit;

  // Candidate history/fill if the current bit were accepted.
  assign w_nh     = {r_history[PAT_LEN-2:0], in_bit};
  assign w_nf     = (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + FW'(1);
  assign w_accept = in_valid && !pat_load;
  assign w_hit    = w_accept && (w_nf == FW'(PAT_LEN)) && (w_nh == r_pattern);

  // State registers; the pattern resets to all-ones for legacy behaviour.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_history <= '0;
      r_pattern <= {PAT_LEN{1'b1}};
      r_fill    <= '0;
      r_state   <= S_EMPTY;
      r_match   <= 1'b0;
    end else begin
      r_history <= w_history_nxt;
      r_pattern <= w_pattern_nxt;
      r_fill    <= w_fill_nxt;
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
    end
  end

  // Next-state logic: pat_load beats in_valid; idle cycles hold everything.
  always_comb begin
    w_history_nxt = r_history;
    w_pattern_nxt = r_pattern;
    w_fill_nxt    = r_fill;
    w_state_nxt   = r_state;
    w_match_nxt   = 1'b0;

    if (pat_load) begin
      w_pattern_nxt = pat_in;
      w_history_nxt = '0;
      w_fill_nxt    = '0;
      w_state_nxt   = S_EMPTY;
    end else if (in_valid) begin
      if (w_hit) begin
        w_match_nxt = 1'b1;
        w_state_nxt = S_HIT;
        if (overlap) begin
          w_history_nxt = w_nh;
          w_fill_nxt    = FW'(PAT_LEN);
        end else begin
          w_history_nxt = '0;
          w_fill_nxt    = '0;
        end
      end else begin
        w_history_nxt = w_nh;
        w_fill_nxt    = w_nf;
        w_state_nxt   = (w_nf == FW'(PAT_LEN)) ? S_ARMED : S_FILL;
      end
    end
  end

  // Match counter bumps on the same edge that registers the match pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk_2 (clk_2),
    .reset (reset),
    .inc   (w_hit),
    .q     (match_count)
  );

  assign match   = r_match;
  assign fill    = r_fill;
  assign state_o = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed plan steps plus random traffic,
// checked against a queue-based model of the last accepted bits.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int unsigned PL = 4;

  logic          clk_2    = 1'b0;
  logic          reset    = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_bit   = 1'b0;
  logic          pat_load = 1'b0;
  logic [PL-1:0] pat_in   = '0;
  logic          overlap  = 1'b1;

  logic       m_a, m_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] fill_a, fill_b;
  logic [1:0] st_a, st_b;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: bits accepted since the last clear (oldest first).
  int   q[$];
  int   pat       = 15;
  bit   last_hit  = 1'b0;
  int   cnt       = 0;
  logic exp_match = 1'b0;
  logic ovl_cur   = 1'b1;

  seq_detector_param #(.PAT_LEN(PL), .CNT_W(8)) dut_a (
    .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .match(m_a), .match_count(cnt_a), .fill(fill_a), .state_o(st_a)
  );

  seq_detector_param #(.PAT_LEN(PL), .CNT_W(2)) dut_b (
    .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .match(m_b), .match_count(cnt_b), .fill(fill_b), .state_o(st_b)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_state();
    if (last_hit)          return int'(S_HIT);
    if (q.size() == 0)     return int'(S_EMPTY);
    if (q.size() < int'(PL)) return int'(S_FILL);
    return int'(S_ARMED);
  endfunction

  // One clock: drive inputs, advance model at the edge, check both DUTs.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [PL-1:0] pin, input logic ovl, input logic rst);
    int  val;
    bit  hit;
    reset = rst; in_valid = v; in_bit = b; pat_load = ld; pat_in = pin; overlap = ovl;
    @(posedge clk_2);
    if (rst) begin
      q.delete(); pat = 15; last_hit = 1'b0; cnt = 0; exp_match = 1'b0;
    end else if (ld) begin
      pat = int'(pin); q.delete(); last_hit = 1'b0; exp_match = 1'b0;
    end else if (v) begin
      q.push_back(int'(b));
      if (q.size() > int'(PL)) void'(q.pop_front());
      val = 0;
      for (int i = 0; i < q.size(); i++) val = (val << 1) | q[i];
      hit = (q.size() == int'(PL)) && (val == pat);
      exp_match = hit;
      last_hit  = hit;
      if (hit) begin
        cnt++;
        if (!ovl) q.delete();
      end
    end else begin
      exp_match = 1'b0;
    end
    #1;
    chk("match_a", 32'(m_a), 32'(exp_match));
    chk("match_b", 32'(m_b), 32'(exp_match));
    chk("count_a", 32'(cnt_a), 32'((cnt > 255) ? 255 : cnt));
    chk("count_b", 32'(cnt_b), 32'((cnt > 3) ? 3 : cnt));
    chk("fill_a", 32'(fill_a), 32'(q.size()));
    chk("fill_b", 32'(fill_b), 32'(q.size()));
    chk("state_a", 32'(st_a), 32'(exp_state()));
    chk("state_b", 32'(st_b), 32'(exp_state()));
  endtask

  task automatic samp(input logic b);
    step(1'b1, b, 1'b0, '0, ovl_cur, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, ovl_cur, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, ovl_cur, 1'b1);
  endtask

  task automatic load(input logic [PL-1:0] p);
    step(1'b0, 1'b0, 1'b1, p, ovl_cur, 1'b0);
  endtask

  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;

    // Reset state
    do_reset();
    do_reset();
    chk("rst_match", 32'(m_a), 32'(0));
    chk("rst_state", 32'(st_a), 32'(S_EMPTY));

    // Plan 1: overlapping 1011 on 1011011 -> two matches
    ovl_cur = 1'b1;
    load(4'b1011);
    for (int i = 6; i >= 0; i--) samp(stream[i]);
    chk("t1_count", 32'(cnt_a), 32'(2));

    // Plan 2: non-overlapping, same stream -> one more match, fill ends at 3
    ovl_cur = 1'b0;
    load(4'b1011);
    for (int i = 6; i >= 3; i--) samp(stream[i]);
    chk("t2_fill0", 32'(fill_a), 32'(0));
    chk("t2_hit_state", 32'(st_a), 32'(S_HIT));
    for (int i = 2; i >= 0; i--) samp(stream[i]);
    chk("t2_count", 32'(cnt_a), 32'(3));
    chk("t2_fill3", 32'(fill_a), 32'(3));

    // Plan 3: default all-ones pattern, continuous ones then a zero
    ovl_cur = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) samp(1'b1);
    chk("t3_match", 32'(m_a), 32'(1));
    samp(1'b0);
    for (int i = 0; i < 3; i++) samp(1'b1);
    chk("t3_nomatch", 32'(m_a), 32'(0));
    samp(1'b1);
    chk("t3_rematch", 32'(m_a), 32'(1));

    // Plan 4: 8 ones with a 2-bit counter saturates at 3
    do_reset();
    for (int i = 0; i < 8; i++) samp(1'b1);
    chk("t4_sat_b", 32'(cnt_b), 32'(3));
    chk("t4_cnt_a", 32'(cnt_a), 32'(5));

    // Plan 5: pat_load with a concurrent sample discards the sample
    do_reset();
    load(4'b1011);
    samp(1'b1); samp(1'b0); samp(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1011, ovl_cur, 1'b0);
    chk("t5_fill", 32'(fill_a), 32'(0));
    chk("t5_state", 32'(st_a), 32'(S_EMPTY));
    samp(1'b1); samp(1'b0); samp(1'b1);
    chk("t5_nomatch", 32'(m_a), 32'(0));
    samp(1'b1);
    chk("t5_match", 32'(m_a), 32'(1));
    chk("t5_count", 32'(cnt_a), 32'(1));

    // Plan 6: gaps between samples, single-cycle pulse, reset mid-stream
    for (int i = 6; i >= 0; i--) begin
      samp(stream[i]);
      idle();
    end
    chk("t6_count", 32'(cnt_a), 32'(3));
    samp(1'b1); samp(1'b0);
    do_reset();
    chk("t6_rst_fill", 32'(fill_a), 32'(0));
    chk("t6_rst_count", 32'(cnt_a), 32'(0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, b, ld, ovl, rst;
      logic [PL-1:0] p;
      v   = ($urandom_range(0, 9) < 7);
      b   = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      ovl = 1'($urandom_range(0, 1));
      p   = PL'($urandom_range(0, 15));
      ovl_cur = ovl;
      step(v, b, ld, p, ovl, rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
